serial_dense_stage: RTL and testbench

SERIAL_DENSE_STAGE -- requirements
Module: serial_dense_stage

---
 rtl/nn_pkg.sv | 29 ++
 rtl/argmax_tree.sv | 33 +++
 rtl/serial_dense_stage.sv | 107 ++++++++++
 tb/tb_serial_dense_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared width derivations, state encoding and saturation helper
package nn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } dense_state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_bw(input int bw, input int bw_w, input int in_ch);
    return bw + bw_w + $clog2(in_ch);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/argmax_tree.sv
// rtl/argmax_tree.sv - combinational pairwise compare tree, lowest index wins ties
module argmax_tree import nn_pkg::*; #(
  parameter  int OUT_CH = 16,
  parameter  int BW     = 16,
  localparam int IW     = addr_w(OUT_CH)
) (
  input  logic [OUT_CH-1:0][BW-1:0] vals,
  output logic [IW-1:0]             idx
);

  localparam int LEAVES = 1 << IW;

  always_comb begin
    logic signed [BW-1:0] v  [LEAVES];
    logic [IW-1:0]        ix [LEAVES];
    for (int i = 0; i < LEAVES; i++) begin
      if (i < OUT_CH) v[i] = vals[i];
      else            v[i] = {1'b1, {(BW-1){1'b0}}};
      ix[i] = IW'(i);
    end
    // Left operand always carries the lower index, so strict > keeps it on ties.
    for (int s = 1; s < LEAVES; s = s * 2) begin
      for (int i = 0; i < LEAVES; i = i + 2 * s) begin
        if (v[i+s] > v[i]) begin
          v[i]  = v[i+s];
          ix[i] = ix[i+s];
        end
      end
    end
    idx = ix[0];
  end

endmodule

// File: rtl/serial_dense_stage.sv
// rtl/serial_dense_stage.sv - serial dense layer: one input word per cycle into OUT_CH parallel MACs
module serial_dense_stage import nn_pkg::*; #(
  parameter  int BW      = 16,
  parameter  int IN_CH   = 64,
  parameter  int OUT_CH  = 16,
  parameter  int BW_W    = 8,
  parameter  int R_SHIFT = 8,
  parameter  int RELU_EN = 1,
  localparam int ACC_BW  = acc_bw(BW, BW_W, IN_CH),
  localparam int AW      = addr_w(IN_CH),
  localparam int IW      = addr_w(OUT_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vld_in,
  output logic                          rdy_in,
  input  logic [IN_CH-1:0][BW-1:0]      data_in,
  output logic [AW-1:0]                 w_addr,
  input  logic [OUT_CH-1:0][BW_W-1:0]   w_vec,
  output logic                          vld_out,
  output logic [OUT_CH-1:0][BW-1:0]     data_out,
  output logic [IW-1:0]                 argmax
);

  dense_state_t state, state_nxt;
  logic [AW-1:0]               k;
  logic [IN_CH-1:0][BW-1:0]    vec;
  logic signed [ACC_BW-1:0]    acc     [OUT_CH];
  logic signed [ACC_BW-1:0]    acc_nxt [OUT_CH];
  logic [OUT_CH-1:0][BW-1:0]   res;
  logic [IW-1:0]               res_idx;
  logic                        accept;
  logic                        last;

  assign accept = vld_in & rdy_in;
  assign last   = (state == S_MAC) && (k == AW'(IN_CH - 1));

  always_comb begin
    state_nxt = state;
    rdy_in    = 1'b0;
    vld_out   = 1'b0;
    w_addr    = '0;
    case (state)
      S_IDLE: begin
        rdy_in = 1'b1;
        if (vld_in) state_nxt = S_MAC;
      end
      S_MAC: begin
        w_addr = k;
        if (k == AW'(IN_CH - 1)) state_nxt = S_OUT;
      end
      S_OUT: begin
        rdy_in    = 1'b1;
        vld_out   = 1'b1;
        state_nxt = vld_in ? S_MAC : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Results are formed from acc_nxt so the final word lands in data_out on the OUT entry edge.
  always_comb begin
    logic signed [ACC_BW-1:0] scaled;
    logic signed [63:0]       wide;
    for (int j = 0; j < OUT_CH; j++) begin
      acc_nxt[j] = acc[j] + ACC_BW'($signed(vec[k])) * ACC_BW'($signed(w_vec[j]));
      scaled     = acc_nxt[j] >>> R_SHIFT;
      wide       = 64'(scaled);
      if (RELU_EN != 0 && wide < 0) wide = '0;
      res[j] = BW'(saturate(wide, BW));
    end
  end

  argmax_tree #(
    .OUT_CH (OUT_CH),
    .BW     (BW)
  ) u_argmax (
    .vals (res),
    .idx  (res_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      k        <= '0;
      vec      <= '0;
      data_out <= '0;
      argmax   <= '0;
      for (int j = 0; j < OUT_CH; j++) acc[j] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        vec <= data_in;
        k   <= '0;
        for (int j = 0; j < OUT_CH; j++) acc[j] <= '0;
      end else if (state == S_MAC) begin
        k <= k + 1'b1;
        for (int j = 0; j < OUT_CH; j++) acc[j] <= acc_nxt[j];
        if (last) begin
          data_out <= res;
          argmax   <= res_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_dense_stage.sv
// tb/tb_serial_dense_stage.sv - randomized bench for serial_dense_stage against a dot-product model
module tb_serial_dense_stage;

  localparam int BW     = 16;
  localparam int IN_CH  = 4;
  localparam int OUT_CH = 2;
  localparam int BW_W   = 8;
  localparam int NCFG   = 3;

  logic clk = 1'b0;
  logic rst;
  logic vld_in;
  logic [IN_CH-1:0][BW-1:0]    data_in;
  logic                        rdy_in   [NCFG];
  logic                        vld_out  [NCFG];
  logic [1:0]                  w_addr   [NCFG];
  logic [OUT_CH-1:0][BW_W-1:0] w_vec    [NCFG];
  logic [OUT_CH-1:0][BW-1:0]   data_out [NCFG];
  logic [0:0]                  argmax   [NCFG];

  logic signed [BW_W-1:0] rom [IN_CH][OUT_CH];
  int vec [IN_CH];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int d = 0; d < NCFG; d++)
      for (int j = 0; j < OUT_CH; j++)
        w_vec[d][j] = rom[w_addr[d]][j];
  end

  // cfg 0: linear, no shift; cfg 1: ReLU, no shift; cfg 2: linear, shift by 8
  for (genvar d = 0; d < NCFG; d++) begin : g_dut
    serial_dense_stage #(
      .BW      (BW),
      .IN_CH   (IN_CH),
      .OUT_CH  (OUT_CH),
      .BW_W    (BW_W),
      .R_SHIFT ((d == 2) ? 8 : 0),
      .RELU_EN ((d == 1) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .vld_in   (vld_in),
      .rdy_in   (rdy_in[d]),
      .data_in  (data_in),
      .w_addr   (w_addr[d]),
      .w_vec    (w_vec[d]),
      .vld_out  (vld_out[d]),
      .data_out (data_out[d]),
      .argmax   (argmax[d])
    );
  end

  function automatic longint model_out(input int cfg, input int j);
    longint sum = 0;
    for (int k = 0; k < IN_CH; k++) sum += longint'(vec[k]) * longint'(rom[k][j]);
    if (cfg == 2) sum = sum >>> 8;
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    if (cfg == 1 && sum < 0) sum = 0;
    return sum;
  endfunction

  function automatic int model_argmax(input int cfg);
    int best = 0;
    for (int j = 1; j < OUT_CH; j++)
      if (model_out(cfg, j) > model_out(cfg, best)) best = j;
    return best;
  endfunction

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_vec();
    for (int k = 0; k < IN_CH; k++) data_in[k] = 16'(vec[k]);
  endtask

  task automatic rand_vec();
    logic signed [15:0] r;
    for (int k = 0; k < IN_CH; k++) begin
      r = 16'($urandom);
      vec[k] = int'(r) >>> $urandom_range(0, 14);
    end
  endtask

  task automatic rand_rom();
    for (int k = 0; k < IN_CH; k++)
      for (int j = 0; j < OUT_CH; j++) rom[k][j] = 8'($urandom);
  endtask

  task automatic check_idle_outs(input string tag);
    for (int d = 0; d < NCFG; d++) begin
      check_eq($sformatf("%s rdy_in c%0d", tag, d), rdy_in[d], 1);
      check_eq($sformatf("%s vld_out c%0d", tag, d), vld_out[d], 0);
      check_eq($sformatf("%s w_addr c%0d", tag, d), w_addr[d], 0);
    end
  endtask

  task automatic check_result(input string tag);
    for (int d = 0; d < NCFG; d++) begin
      check_eq($sformatf("%s vld_out c%0d", tag, d), vld_out[d], 1);
      check_eq($sformatf("%s rdy_in c%0d", tag, d), rdy_in[d], 1);
      for (int j = 0; j < OUT_CH; j++)
        check_eq($sformatf("%s data_out c%0d[%0d]", tag, d, j),
                 $signed(data_out[d][j]), model_out(d, j));
      check_eq($sformatf("%s argmax c%0d", tag, d), argmax[d], model_argmax(d));
    end
  endtask

  task automatic run_batch(input string tag, input int n, input bit rnd,
                           input bit garbage, input bit b2b);
    @(negedge clk);
    if (rnd) rand_vec();
    drive_vec();
    vld_in = 1'b1;
    check_eq({tag, " rdy_in before accept"}, rdy_in[0], 1);
    for (int v = 0; v < n; v++) begin
      @(posedge clk);
      for (int i = 0; i <= IN_CH; i++) begin
        @(negedge clk);
        if (i < IN_CH) begin
          for (int d = 0; d < NCFG; d++) begin
            check_eq($sformatf("%s w_addr c%0d", tag, d), w_addr[d], i);
            check_eq($sformatf("%s vld_out early c%0d", tag, d), vld_out[d], 0);
            check_eq($sformatf("%s rdy_in mac c%0d", tag, d), rdy_in[d], 0);
          end
          vld_in = garbage;
          if (garbage) for (int k = 0; k < IN_CH; k++) data_in[k] = 16'($urandom);
        end else begin
          check_result(tag);
          check_eq({tag, " w_addr out"}, w_addr[0], 0);
          if (b2b && v < n - 1) begin
            if (rnd) rand_vec();
            drive_vec();
            vld_in = 1'b1;
          end else begin
            vld_in = 1'b0;
          end
        end
      end
      if (!(b2b && v < n - 1)) begin
        @(negedge clk);
        for (int d = 0; d < NCFG; d++)
          check_eq($sformatf("%s vld_out drop c%0d", tag, d), vld_out[d], 0);
        if (v < n - 1) begin
          if (rnd) rand_vec();
          drive_vec();
          vld_in = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    vld_in  = 1'b0;
    data_in = '0;
    for (int k = 0; k < IN_CH; k++) begin
      vec[k] = 0;
      for (int j = 0; j < OUT_CH; j++) rom[k][j] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outs("reset");
    for (int d = 0; d < NCFG; d++) begin
      check_eq($sformatf("reset data_out c%0d", d), data_out[d], 0);
      check_eq($sformatf("reset argmax c%0d", d), argmax[d], 0);
    end
    rst = 1'b0;

    vec = '{1, 2, 3, 4};
    for (int k = 0; k < IN_CH; k++) begin
      rom[k][0] = 8'(k + 1);
      rom[k][1] = -8'sd1;
    end
    run_batch("basic", 1, 1'b0, 1'b0, 1'b0);

    vec = '{32767, 32767, 32767, 32767};
    for (int k = 0; k < IN_CH; k++) begin rom[k][0] = 8'sd127; rom[k][1] = 8'sd127; end
    run_batch("sat_pos", 1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < IN_CH; k++) begin rom[k][0] = -8'sd128; rom[k][1] = -8'sd128; end
    run_batch("sat_neg", 1, 1'b0, 1'b0, 1'b0);
    vec = '{256, 256, 256, 256};
    for (int k = 0; k < IN_CH; k++) begin rom[k][0] = 8'sd1; rom[k][1] = 8'sd1; end
    run_batch("shift", 1, 1'b0, 1'b0, 1'b0);

    vec = '{5, 0, 0, 0};
    for (int k = 0; k < IN_CH; k++) begin rom[k][0] = '0; rom[k][1] = '0; end
    rom[0][0] = 8'sd1; rom[0][1] = 8'sd1;
    run_batch("tie", 1, 1'b0, 1'b0, 1'b0);
    vec = '{1, 0, 0, 0};
    rom[0][0] = 8'sd3; rom[0][1] = 8'sd7;
    run_batch("max1", 1, 1'b0, 1'b0, 1'b0);

    rand_rom();
    run_batch("ignored", 1, 1'b1, 1'b1, 1'b0);
    run_batch("b2b", 3, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    rand_vec();
    drive_vec();
    vld_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outs("abort");
    for (int d = 0; d < NCFG; d++)
      check_eq($sformatf("abort data_out c%0d", d), data_out[d], 0);
    repeat (IN_CH + 2) begin
      @(negedge clk);
      for (int d = 0; d < NCFG; d++)
        check_eq($sformatf("abort no pulse c%0d", d), vld_out[d], 0);
    end
    run_batch("after_abort", 1, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      rand_rom();
      run_batch($sformatf("rand%0d", r), 2, 1'b1, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
